// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard control unit: flow decisions, PC mux selects, FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        BjSeq  = 2'b00,
        BjBrNt = 2'b01,
        BjBrTk = 2'b10,
        BjJump = 2'b11
    } bj_e;

    typedef enum logic [1:0] {
        PcPlus4  = 2'b00,
        PcBranch = 2'b01,
        PcJump   = 2'b10,
        PcExcVec = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLdStall = 2'b01,
        StIntHold = 2'b10
    } state_e;

    localparam int unsigned CntW = 4;

endpackage

// File: rtl/hz_down_counter.sv
// 4-bit loadable down-counter with zero flag; shared by the load-stall and interrupt-hold states.
module hz_down_counter
    import hazard_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    output logic            zero_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump redirects and optional interrupt entry.
// Interrupt support (INTHOLD state, int_req path) is built only when HAZARD_INT_EN is defined.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned INT_HOLD = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_ex_memread,
    input  logic [RA_W-1:0] id_ex_rt,
    input  logic [RA_W-1:0] if_id_rs,
    input  logic [RA_W-1:0] if_id_rt,
    input  logic            if_id_uses_rt,
    input  logic [1:0]      branch_or_jump,
    input  logic            int_req,
    output logic            pc_write,
    output logic            if_id_stall,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic [1:0]      pc_sel,
    output logic            epc_we,
    output logic            int_ack
);

    // The RUN cycle that detects the hazard is the first stall cycle, hence the -2.
    localparam logic [CntW-1:0] LdCnt = CntW'(MEM_LAT - 2);

    state_e          state_q, state_d;
    logic            hazard;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic [CntW-1:0] cnt_load_val;
    pc_sel_e         flow_sel;
    logic            flow_flush;

`ifdef HAZARD_INT_EN
    localparam logic [CntW-1:0] IntCnt = CntW'(INT_HOLD - 1);
`else
    logic            unused_int_req;
    logic [CntW-1:0] unused_int_hold;
    assign unused_int_req  = int_req;
    assign unused_int_hold = CntW'(INT_HOLD);
`endif

    assign hazard = id_ex_memread && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    always_comb begin
        flow_sel   = PcPlus4;
        flow_flush = 1'b0;
        case (bj_e'(branch_or_jump))
            BjBrTk: begin
                flow_sel   = PcBranch;
                flow_flush = 1'b1;
            end
            BjJump: begin
                flow_sel   = PcJump;
                flow_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        pc_write     = 1'b1;
        pc_sel       = PcPlus4;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        epc_we       = 1'b0;
        int_ack      = 1'b0;

        if (reset) begin
            case (state_q)
                StRun: begin
`ifdef HAZARD_INT_EN
                    if (int_req) begin
                        pc_sel       = PcExcVec;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        epc_we       = 1'b1;
                        int_ack      = 1'b1;
                        state_d      = StIntHold;
                        cnt_load     = 1'b1;
                        cnt_load_val = IntCnt;
                    end else
`endif
                    if (hazard) begin
                        pc_write    = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        if (MEM_LAT > 1) begin
                            state_d      = StLdStall;
                            cnt_load     = 1'b1;
                            cnt_load_val = LdCnt;
                        end
                    end else begin
                        pc_sel      = flow_sel;
                        if_id_flush = flow_flush;
                        id_ex_flush = flow_flush;
                    end
                end
                StLdStall: begin
                    pc_write    = 1'b0;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    if (cnt_zero) begin
                        state_d = StRun;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
`ifdef HAZARD_INT_EN
                StIntHold: begin
                    // Hazard stalls this cycle only; the long stall resumes from RUN.
                    if (hazard) begin
                        pc_write    = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_sel      = flow_sel;
                        if_id_flush = flow_flush;
                        id_ex_flush = flow_flush;
                    end
                    if (cnt_zero) begin
                        state_d = StRun;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
`endif
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    hz_down_counter u_cnt (
        .clk_i      (clk),
        .reset_ni   (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (MEM_LAT 1/3/4) share one stimulus stream.
// Interrupt scenarios are exercised when HAZARD_INT_EN is defined.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_ex_memread = 1'b0;
    logic [4:0] id_ex_rt = '0;
    logic [4:0] if_id_rs = '0;
    logic [4:0] if_id_rt = '0;
    logic       if_id_uses_rt = 1'b0;
    logic [1:0] branch_or_jump = 2'b00;
    logic       int_req = 1'b0;

    // Packed view: {pc_write, pc_sel[1:0], if_id_stall, if_id_flush, id_ex_flush, epc_we, int_ack}
    logic [7:0] o1, o3, o4;

    localparam logic [7:0] ExpRun   = {1'b1, 2'b00, 5'b00000};
    localparam logic [7:0] ExpStall = {1'b0, 2'b00, 5'b10100};
    localparam logic [7:0] ExpBrTk  = {1'b1, 2'b01, 5'b01100};
    localparam logic [7:0] ExpJump  = {1'b1, 2'b10, 5'b01100};
    localparam logic [7:0] ExpInt   = {1'b1, 2'b11, 5'b01111};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.RA_W(5), .MEM_LAT(1), .INT_HOLD(2)) u1 (
        .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .branch_or_jump(branch_or_jump), .int_req(int_req),
        .pc_write(o1[7]), .pc_sel(o1[6:5]), .if_id_stall(o1[4]), .if_id_flush(o1[3]),
        .id_ex_flush(o1[2]), .epc_we(o1[1]), .int_ack(o1[0])
    );

    hazard_ctrl_unit #(.RA_W(5), .MEM_LAT(3), .INT_HOLD(2)) u3 (
        .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .branch_or_jump(branch_or_jump), .int_req(int_req),
        .pc_write(o3[7]), .pc_sel(o3[6:5]), .if_id_stall(o3[4]), .if_id_flush(o3[3]),
        .id_ex_flush(o3[2]), .epc_we(o3[1]), .int_ack(o3[0])
    );

    hazard_ctrl_unit #(.RA_W(5), .MEM_LAT(4), .INT_HOLD(2)) u4 (
        .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .branch_or_jump(branch_or_jump), .int_req(int_req),
        .pc_write(o4[7]), .pc_sel(o4[6:5]), .if_id_stall(o4[4]), .if_id_flush(o4[3]),
        .id_ex_flush(o4[2]), .epc_we(o4[1]), .int_ack(o4[0])
    );

    // Start a new cycle: inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_ex_memread  = 1'b0;
        id_ex_rt       = '0;
        if_id_rs       = '0;
        if_id_rt       = '0;
        if_id_uses_rt  = 1'b0;
        branch_or_jump = 2'b00;
        int_req        = 1'b0;
    endtask

    task automatic load_hazard();
        id_ex_memread = 1'b1;
        id_ex_rt      = 5'd5;
        if_id_rs      = 5'd5;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load_hazard();
        branch_or_jump = 2'b10;
        int_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            checks++; if (o1 !== ExpRun) begin failures++; $display("FAIL reset_u1 c%0d got=%h exp=%h", i, o1, ExpRun); end
            checks++; if (o3 !== ExpRun) begin failures++; $display("FAIL reset_u3 c%0d got=%h exp=%h", i, o3, ExpRun); end
            checks++; if (o4 !== ExpRun) begin failures++; $display("FAIL reset_u4 c%0d got=%h exp=%h", i, o4, ExpRun); end
        end
        cyc();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (o4 !== ExpRun) begin failures++; $display("FAIL reset_idle got=%h exp=%h", o4, ExpRun); end
    endtask

    task automatic test_load_use();
        logic [7:0] e1, e3, e4;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) load_hazard(); else clear_inputs();
            @(negedge clk);
            e1 = (i < 1) ? ExpStall : ExpRun;
            e3 = (i < 3) ? ExpStall : ExpRun;
            e4 = (i < 4) ? ExpStall : ExpRun;
            checks++; if (o1 !== e1) begin failures++; $display("FAIL lduse_u1 c%0d got=%h exp=%h", i, o1, e1); end
            checks++; if (o3 !== e3) begin failures++; $display("FAIL lduse_u3 c%0d got=%h exp=%h", i, o3, e3); end
            checks++; if (o4 !== e4) begin failures++; $display("FAIL lduse_u4 c%0d got=%h exp=%h", i, o4, e4); end
        end
    endtask

    task automatic test_no_stall();
        cyc();
        id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
        @(negedge clk);
        checks++; if (o4 !== ExpRun) begin failures++; $display("FAIL r0_no_stall got=%h exp=%h", o4, ExpRun); end
        cyc();
        id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7; if_id_uses_rt = 1'b0;
        @(negedge clk);
        checks++; if (o3 !== ExpRun) begin failures++; $display("FAIL rt_unused got=%h exp=%h", o3, ExpRun); end
        cyc();
        id_ex_memread = 1'b0; if_id_uses_rt = 1'b1;
        @(negedge clk);
        checks++; if (o3 !== ExpRun) begin failures++; $display("FAIL not_load got=%h exp=%h", o3, ExpRun); end
        cyc();
        id_ex_memread = 1'b1;
        @(negedge clk);
        checks++; if (o1 !== ExpStall) begin failures++; $display("FAIL rt_used got=%h exp=%h", o1, ExpStall); end
        clear_inputs();
        for (int i = 0; i < 4; i++) cyc();
        @(negedge clk);
        checks++; if (o4 !== ExpRun) begin failures++; $display("FAIL rt_drain got=%h exp=%h", o4, ExpRun); end
    endtask

    task automatic test_branch();
        logic [1:0] bj [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [7:0] ex [4] = '{ExpBrTk, ExpJump, ExpRun, ExpRun};
        for (int i = 0; i < 4; i++) begin
            cyc();
            branch_or_jump = bj[i];
            @(negedge clk);
            checks++; if (o1 !== ex[i]) begin failures++; $display("FAIL flow_u1 bj=%b got=%h exp=%h", bj[i], o1, ex[i]); end
            checks++; if (o4 !== ex[i]) begin failures++; $display("FAIL flow_u4 bj=%b got=%h exp=%h", bj[i], o4, ex[i]); end
        end
        cyc();
        load_hazard();
        branch_or_jump = 2'b10;
        @(negedge clk);
        checks++; if (o1 !== ExpStall) begin failures++; $display("FAIL haz_br_u1 got=%h exp=%h", o1, ExpStall); end
        checks++; if (o3 !== ExpStall) begin failures++; $display("FAIL haz_br_u3 got=%h exp=%h", o3, ExpStall); end
        cyc();
        id_ex_memread = 1'b0;
        @(negedge clk);
        checks++; if (o1 !== ExpBrTk) begin failures++; $display("FAIL br_after_haz got=%h exp=%h", o1, ExpBrTk); end
        checks++; if (o3 !== ExpStall) begin failures++; $display("FAIL br_in_ldstall got=%h exp=%h", o3, ExpStall); end
        clear_inputs();
        for (int i = 0; i < 4; i++) cyc();
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) load_hazard(); else clear_inputs();
            if (i == 2) reset = 1'b0;
            if (i == 3) reset = 1'b1;
            @(negedge clk);
            if (i == 1) begin
                checks++; if (o4 !== ExpStall) begin failures++; $display("FAIL rst_pre got=%h exp=%h", o4, ExpStall); end
            end else if (i >= 2) begin
                checks++; if (o3 !== ExpRun) begin failures++; $display("FAIL rst_mid_u3 c%0d got=%h exp=%h", i, o3, ExpRun); end
                checks++; if (o4 !== ExpRun) begin failures++; $display("FAIL rst_mid_u4 c%0d got=%h exp=%h", i, o4, ExpRun); end
            end
        end
    endtask

`ifdef HAZARD_INT_EN
    task automatic test_int_hold();
        logic [7:0] ex [5] = '{ExpInt, ExpRun, ExpRun, ExpInt, ExpRun};
        for (int i = 0; i < 5; i++) begin
            cyc();
            int_req = 1'b1;
            @(negedge clk);
            checks++; if (o1 !== ex[i]) begin failures++; $display("FAIL int_u1 c%0d got=%h exp=%h", i, o1, ex[i]); end
            checks++; if (o4 !== ex[i]) begin failures++; $display("FAIL int_u4 c%0d got=%h exp=%h", i, o4, ex[i]); end
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) cyc();
    endtask

    task automatic test_hazard_in_hold();
        logic [7:0] ex [4] = '{ExpInt, ExpStall, ExpBrTk, ExpRun};
        for (int i = 0; i < 4; i++) begin
            cyc();
            clear_inputs();
            if (i == 0) int_req = 1'b1;
            if (i == 1) load_hazard();
            if (i == 2) branch_or_jump = 2'b10;
            @(negedge clk);
            checks++; if (o4 !== ex[i]) begin failures++; $display("FAIL hold_haz_u4 c%0d got=%h exp=%h", i, o4, ex[i]); end
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_int_during_stall();
        logic [7:0] e1 [5] = '{ExpStall, ExpRun, ExpInt, ExpRun, ExpRun};
        logic [7:0] e3 [5] = '{ExpStall, ExpStall, ExpStall, ExpInt, ExpRun};
        logic [7:0] e4 [5] = '{ExpStall, ExpStall, ExpStall, ExpStall, ExpInt};
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) load_hazard(); else id_ex_memread = 1'b0;
            if (i == 2) int_req = 1'b1;
            @(negedge clk);
            checks++; if (o1 !== e1[i]) begin failures++; $display("FAIL int_stall_u1 c%0d got=%h exp=%h", i, o1, e1[i]); end
            checks++; if (o3 !== e3[i]) begin failures++; $display("FAIL int_stall_u3 c%0d got=%h exp=%h", i, o3, e3[i]); end
            checks++; if (o4 !== e4[i]) begin failures++; $display("FAIL int_stall_u4 c%0d got=%h exp=%h", i, o4, e4[i]); end
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) cyc();
    endtask
`else
    task automatic test_int_disabled();
        for (int i = 0; i < 3; i++) begin
            cyc();
            int_req = 1'b1;
            @(negedge clk);
            checks++; if (o1 !== ExpRun) begin failures++; $display("FAIL int_off_u1 c%0d got=%h exp=%h", i, o1, ExpRun); end
            checks++; if (o4 !== ExpRun) begin failures++; $display("FAIL int_off_u4 c%0d got=%h exp=%h", i, o4, ExpRun); end
        end
        cyc();
        int_req = 1'b1;
        branch_or_jump = 2'b11;
        @(negedge clk);
        checks++; if (o3 !== ExpJump) begin failures++; $display("FAIL int_off_jump got=%h exp=%h", o3, ExpJump); end
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_reset_mid_stall();
`ifdef HAZARD_INT_EN
        test_int_hold();
        test_hazard_in_hold();
        test_int_during_stall();
`else
        test_int_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
